// File: rtl/eeprom_rx.sv
// eeprom_rx: SPI mode-0 receiver that clocks DATA_W bits in from the EEPROM, MSB first, and strobes the result
module eeprom_rx #(
  parameter int DIV_LOG2 = 2,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_start,
  input  logic              SDIN,
  output logic              SCLK,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              SPI_busy
);
  localparam int HALF = 2 ** DIV_LOG2;
  localparam int BW   = $clog2(DATA_W) + 1;
  localparam logic [DIV_LOG2:0] PH_RISE = (DIV_LOG2 + 1)'(HALF - 1);
  localparam logic [DIV_LOG2:0] PH_FALL = (DIV_LOG2 + 1)'(2 * HALF - 1);
  localparam logic [BW-1:0]     BIT_LAST = BW'(DATA_W - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t              state;
  logic [DIV_LOG2:0]   phase;
  logic [BW-1:0]       bit_cnt;
  logic [DATA_W-1:0]   sr;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      phase    <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      SCLK     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      SPI_busy <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        SHIFT: begin
          phase <= phase + 1'b1;
          // sample on the rising edge we are about to drive; EEPROM changed SDIN after the previous fall
          if (phase == PH_RISE) begin
            SCLK <= 1'b1;
            sr   <= {sr[DATA_W-2:0], SDIN};
          end
          if (phase == PH_FALL) begin
            SCLK  <= 1'b0;
            phase <= '0;
            if (bit_cnt == BIT_LAST) begin
              state    <= DONE;
              SPI_busy <= 1'b0;
              rd_valid <= 1'b1;
              rd_data  <= sr;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= rd_start ? SHIFT : IDLE;
          if (rd_start) begin
            SPI_busy <= 1'b1;
            phase    <= '0;
            bit_cnt  <= '0;
            sr       <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_eeprom_rx.sv
// tb_eeprom_rx: table, random and hand-sequenced reads against an EEPROM model and waveform expectations
module tb_eeprom_rx;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rd_start = 1'b1;
  logic       sdin;
  logic       sclk0, valid0, busy0, sclk1, valid1, busy1;
  logic [7:0] data0, data1;
  logic       sel = 1'b0;
  logic       sclk, valid, busy;
  logic [7:0] data;
  int         tests = 0, fails = 0;
  int         total_falls = 0, base_falls = 0;
  logic [7:0] txv = 8'h00;
  bit         pending = 0;

  always #5 clk = ~clk;

  eeprom_rx dut (.clk(clk), .reset(reset), .rd_start(rd_start), .SDIN(sdin),
                 .SCLK(sclk0), .rd_data(data0), .rd_valid(valid0), .SPI_busy(busy0));
  eeprom_rx #(.DIV_LOG2(0), .DATA_W(8)) dut1 (.clk(clk), .reset(reset), .rd_start(rd_start), .SDIN(sdin),
                 .SCLK(sclk1), .rd_data(data1), .rd_valid(valid1), .SPI_busy(busy1));

  assign sclk  = sel ? sclk1 : sclk0;
  assign valid = sel ? valid1 : valid0;
  assign busy  = sel ? busy1 : busy0;
  assign data  = sel ? data1 : data0;

  // EEPROM: presents the next bit after each SCLK fall, MSB first
  always @(negedge sclk) total_falls++;
  int idx;
  assign idx  = total_falls - base_falls;
  assign sdin = (idx >= 0 && idx < 8) ? txv[3'(7 - idx)] : 1'b0;

  typedef struct {
    logic [7:0] b;
    int         p1;
    int         p2;
    logic [7:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One read; p1/p2 are extra rd_start pulses at edge E0+p (ignored while busy).
  // With chain set, rd_start is raised in the rd_valid cycle for byte nb.
  task automatic xfer(input logic [7:0] b, input int p1, input int p2, input logic [7:0] exp_data,
                      input bit chain, input logic [7:0] nb);
    int h = sel ? 1 : 4;
    int t = 2 * h * 8;
    int bad_sclk = 0, bad_busy = 0, bad_hold = 0, vcnt = 0, vat = -1, rises = 0;
    logic ps = 1'b0;
    logic [7:0] prevd;
    logic [7:0] got = 8'h00;
    if (!pending) begin
      @(negedge clk);
      txv = b;
      base_falls = total_falls;
      rd_start = 1'b1;
    end
    pending = 0;
    prevd = data;
    for (int k = 0; k <= t + 2; k++) begin
      @(negedge clk);
      if (sclk !== ((k < t) && ((k / h) % 2 == 1))) bad_sclk++;
      if (busy !== (k < t)) bad_busy++;
      if (k < t && data !== prevd) bad_hold++;
      if (sclk && !ps) rises++;
      ps = sclk;
      if (valid) begin vcnt++; vat = k; end
      if (k == t) got = data;
      rd_start = (k + 1 == p1 || k + 1 == p2);
      if (chain && k == t) begin
        txv = nb;
        base_falls = total_falls;
        rd_start = 1'b1;
        pending = 1;
        break;
      end
    end
    chk("sclk_wave", bad_sclk, 0);
    chk("busy_wave", bad_busy, 0);
    chk("data_hold", bad_hold, 0);
    chk("sclk_rises", rises, 8);
    chk("valid_count", vcnt, 1);
    chk("valid_at", vat, t);
    chk("rd_data", got, exp_data);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'hA5, -1, -1, 8'hA5};
    vecs[1] = '{8'h5A, 10, 40, 8'h5A};
    vecs[2] = '{8'h00, 1, 63, 8'h00};
    vecs[3] = '{8'hFF, 32, 64, 8'hFF};
    vecs[4] = '{8'h96, 4, 60, 8'h96};

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_sclk", sclk0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_valid", valid0, 0);
      chk("rst_data", data0, 0);
    end
    reset = 1'b0;
    rd_start = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) xfer(vecs[i].b, vecs[i].p1, vecs[i].p2, vecs[i].exp_data, 0, 8'h00);

    xfer(8'h3C, -1, -1, 8'h3C, 1, 8'hC3);
    xfer(8'hC3, -1, -1, 8'hC3, 0, 8'h00);

    for (int i = 0; i < 16; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      xfer(r, int'($urandom_range(1, 64)), int'($urandom_range(1, 64)), r, 0, 8'h00);
    end

    begin
      int vc = 0, bb = 0;
      @(negedge clk);
      txv = 8'hE7;
      base_falls = total_falls;
      rd_start = 1'b1;
      @(negedge clk);
      rd_start = 1'b0;
      repeat (29) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_sclk", sclk0, 0);
      chk("midrst_busy", busy0, 0);
      chk("midrst_valid", valid0, 0);
      chk("midrst_data", data0, 0);
      for (int k = 0; k < 80; k++) begin
        @(negedge clk);
        if (valid0) vc++;
        if (busy0 || sclk0) bb++;
      end
      chk("midrst_no_valid", vc, 0);
      chk("midrst_idle", bb, 0);
    end
    xfer(8'h81, -1, -1, 8'h81, 0, 8'h00);

    sel = 1'b1;
    repeat (2) @(negedge clk);
    xfer(8'hFF, -1, -1, 8'hFF, 0, 8'h00);
    xfer(8'h00, 5, 16, 8'h00, 0, 8'h00);
    xfer(8'h6B, -1, -1, 8'h6B, 1, 8'h94);
    xfer(8'h94, -1, -1, 8'h94, 0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
